// File: rtl/nios_debug_ocimem_ctrl_if.sv
// ----------------------------------------------------------------------------
// nios_debug_ocimem_ctrl_if
// CPU-side Avalon-MM slave bus of the debug-memory sequencer.
//   cpu_address     : word address (ADDR_W bits), master -> slave
//   cpu_read        : read request, master -> slave
//   cpu_write       : write request, master -> slave
//   cpu_writedata   : 32-bit write data, master -> slave
//   cpu_byteenable  : byte lanes for writes, master -> slave
//   cpu_readdata    : 32-bit read data, slave -> master
//   cpu_waitrequest : stall, slave -> master (combinational in the slave)
// ----------------------------------------------------------------------------
interface nios_debug_ocimem_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    output cpu_readdata, cpu_waitrequest
  );

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    input  cpu_readdata, cpu_waitrequest
  );
endinterface

// File: rtl/nios_debug_ocimem_ctrl.sv
// ----------------------------------------------------------------------------
// nios_debug_ocimem_ctrl
// Debug-memory sequencer of the Nios II debug module. Latches the sysclk JTAG
// command strobes with their jdo word, and arbitrates a single-port debug RAM
// between those JTAG commands (strict priority) and a CPU Avalon-MM slave.
//
// Ports:
//   clk                     : system clock
//   reset_n                 : synchronous active-low reset (RAM content kept)
//   jdo[37:0]               : JTAG data word from the debug-slave wrapper
//   take_action_ocimem_a    : strobe, load JTAG address / control
//   take_action_ocimem_b    : strobe, JTAG full-word write + address increment
//   take_no_action_ocimem_a : strobe, JTAG read + address increment
//   cpu (slave modport)     : CPU Avalon-MM access to the same RAM
//   MonDReg[31:0]           : last JTAG read data
//   monitor_ready           : JTAG read data valid
//   monitor_error           : sticky RAM parity error
//
// Parameters:
//   ADDR_W    : RAM word-address width (depth 2^ADDR_W, ADDR_W <= 17)
//   INIT_FILE : optional preload image name; empty means undefined content
//
// Build option DEBUG_RAM_PARITY_EN: adds one even-parity bit per byte lane to
// every RAM word; a mismatch on any read sets monitor_error until cleared by
// an address load with jdo[34]=1 or by reset. Without it monitor_error is 0.
// ----------------------------------------------------------------------------
module nios_debug_ocimem_ctrl #(
  parameter int unsigned ADDR_W    = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [37:0]                    jdo,
  input  logic                           take_action_ocimem_a,
  input  logic                           take_action_ocimem_b,
  input  logic                           take_no_action_ocimem_a,
  nios_debug_ocimem_ctrl_if.slave        cpu,
  output logic [31:0]                    MonDReg,
  output logic                           monitor_ready,
  output logic                           monitor_error
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LANES     = 4;
  localparam int unsigned DEPTH     = 1 << ADDR_W;
  // The slot keeps jdo[34:3]; the JTAG address field jdo[ADDR_W+17:18]
  // therefore starts at bit 15 of the slot and the clear flag jdo[34] is bit 31.
  localparam int unsigned JADDR_LSB = 15;
  localparam int unsigned JCLR_BIT  = 31;
`ifdef DEBUG_RAM_PARITY_EN
  localparam int unsigned RAM_W     = DATA_W + LANES;
`else
  localparam int unsigned RAM_W     = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE, JRD, CRD} state_e;
  typedef enum logic [1:0] {CMD_ADDR, CMD_WR, CMD_RD} cmd_e;

  // Preload images are attached by the implementation flow's memory-init
  // mechanism; the RTL itself never initialises the array.
  if (INIT_FILE != "") begin : g_init_file
  end

  state_e                 state_q, state_d;
  logic                   pend_valid_q;
  cmd_e                   pend_cmd_q;
  logic [DATA_W-1:0]      pend_data_q;
  logic                   pend_clr;

  logic [ADDR_W-1:0]      jmem_addr_q, jmem_addr_d;
  logic [DATA_W-1:0]      mondreg_q, mondreg_d;
  logic                   mon_ready_q, mon_ready_d;

  logic [RAM_W-1:0]       mem_q [DEPTH];
  logic [RAM_W-1:0]       jrd_q;
  logic [RAM_W-1:0]       cpu_rd_q;

  logic [ADDR_W-1:0]      ram_addr;
  logic [LANES-1:0]       ram_be;
  logic [RAM_W-1:0]       ram_wdata;
  logic                   jrd_re;
  logic                   cpu_re;
  logic                   cpu_req;
  logic                   waitreq_c;

  // Only jdo[34:3] carries information for this block.
  logic                   unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Expand a data word into a RAM word (adds even parity per byte if enabled).
  function automatic logic [RAM_W-1:0] ram_word(input logic [DATA_W-1:0] d);
    logic [RAM_W-1:0] w;
    w = '0;
    w[DATA_W-1:0] = d;
`ifdef DEBUG_RAM_PARITY_EN
    for (int b = 0; b < LANES; b++) begin
      w[DATA_W+b] = ^d[8*b +: 8];
    end
`endif
    return w;
  endfunction

`ifdef DEBUG_RAM_PARITY_EN
  function automatic logic parity_bad(input logic [RAM_W-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < LANES; b++) begin
      bad = bad | (w[DATA_W+b] ^ (^w[8*b +: 8]));
    end
    return bad;
  endfunction
`endif

  assign cpu_req = cpu.cpu_read | cpu.cpu_write;

  // Single pending JTAG slot; a new strobe overwrites, clear only when idle of strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
      pend_cmd_q   <= CMD_ADDR;
      pend_data_q  <= '0;
    end else if (take_action_ocimem_a) begin
      pend_valid_q <= 1'b1;
      pend_cmd_q   <= CMD_ADDR;
      pend_data_q  <= jdo[34:3];
    end else if (take_action_ocimem_b) begin
      pend_valid_q <= 1'b1;
      pend_cmd_q   <= CMD_WR;
      pend_data_q  <= jdo[34:3];
    end else if (take_no_action_ocimem_a) begin
      pend_valid_q <= 1'b1;
      pend_cmd_q   <= CMD_RD;
      pend_data_q  <= jdo[34:3];
    end else if (pend_clr) begin
      pend_valid_q <= 1'b0;
    end
  end

  // State and JTAG-side registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      jmem_addr_q <= '0;
      mondreg_q   <= '0;
      mon_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      jmem_addr_q <= jmem_addr_d;
      mondreg_q   <= mondreg_d;
      mon_ready_q <= mon_ready_d;
    end
  end

  // Next state, RAM port control and waitrequest.
  always_comb begin
    state_d     = state_q;
    jmem_addr_d = jmem_addr_q;
    mondreg_d   = mondreg_q;
    mon_ready_d = mon_ready_q;
    pend_clr    = 1'b0;
    ram_addr    = jmem_addr_q;
    ram_be      = '0;
    ram_wdata   = '0;
    jrd_re      = 1'b0;
    cpu_re      = 1'b0;
    waitreq_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          // JTAG owns the RAM this cycle; any CPU request stalls.
          waitreq_c = cpu_req;
          unique case (pend_cmd_q)
            CMD_ADDR: begin
              jmem_addr_d = pend_data_q[JADDR_LSB +: ADDR_W];
              mon_ready_d = 1'b0;
              pend_clr    = 1'b1;
            end
            CMD_WR: begin
              ram_be      = '1;
              ram_wdata   = ram_word(pend_data_q);
              jmem_addr_d = jmem_addr_q + ADDR_W'(1);
              pend_clr    = 1'b1;
            end
            CMD_RD: begin
              jrd_re      = 1'b1;
              jmem_addr_d = jmem_addr_q + ADDR_W'(1);
              state_d     = JRD;
            end
            default: pend_clr = 1'b1;
          endcase
        end else if (cpu.cpu_write) begin
          ram_addr  = cpu.cpu_address;
          ram_be    = cpu.cpu_byteenable;
          ram_wdata = ram_word(cpu.cpu_writedata);
        end else if (cpu.cpu_read) begin
          ram_addr  = cpu.cpu_address;
          cpu_re    = 1'b1;
          waitreq_c = 1'b1;
          state_d   = CRD;
        end
      end
      JRD: begin
        mondreg_d   = jrd_q[DATA_W-1:0];
        mon_ready_d = 1'b1;
        pend_clr    = 1'b1;
        waitreq_c   = cpu_req;
        state_d     = IDLE;
      end
      CRD: begin
        // Read data is already registered; a stray write waits for IDLE.
        waitreq_c = cpu.cpu_write & ~cpu.cpu_read;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Debug RAM write port; no writes while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int b = 0; b < LANES; b++) begin
        if (ram_be[b]) begin
          mem_q[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
`ifdef DEBUG_RAM_PARITY_EN
          mem_q[ram_addr][DATA_W+b] <= ram_wdata[DATA_W+b];
`endif
        end
      end
    end
  end

  // Synchronous read registers: one per requester so CPU read data is valid in CRD.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      jrd_q    <= '0;
      cpu_rd_q <= '0;
    end else begin
      if (jrd_re) begin
        jrd_q <= mem_q[ram_addr];
      end
      if (cpu_re) begin
        cpu_rd_q <= mem_q[ram_addr];
      end
    end
  end

`ifdef DEBUG_RAM_PARITY_EN
  logic mon_err_q;

  // Sticky parity error; clear and set never coincide (different states).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mon_err_q <= 1'b0;
    end else if (state_q == IDLE && pend_valid_q && pend_cmd_q == CMD_ADDR &&
                 pend_data_q[JCLR_BIT]) begin
      mon_err_q <= 1'b0;
    end else if ((state_q == JRD && parity_bad(jrd_q)) ||
                 (state_q == CRD && parity_bad(cpu_rd_q))) begin
      mon_err_q <= 1'b1;
    end
  end

  assign monitor_error = mon_err_q;
`else
  assign monitor_error = 1'b0;
`endif

  assign MonDReg             = mondreg_q;
  assign monitor_ready       = mon_ready_q;
  assign cpu.cpu_readdata    = cpu_rd_q[DATA_W-1:0];
  assign cpu.cpu_waitrequest = waitreq_c;

endmodule

// File: doc/nios_debug_ocimem_ctrl.md
Name: nios_debug_ocimem_ctrl

Overview:
- Debug-memory sequencer that consumes the sysclk-domain JTAG command strobes and the 38-bit `jdo` word from the debug-slave wrapper.
- Owns a small single-port debug RAM. The RAM is shared between JTAG accesses and a CPU-side Avalon-MM slave.
- Produces `MonDReg`, `monitor_ready` and `monitor_error`, which feed back into the debug-slave wrapper's capture path.
- Sits directly downstream of the debug-slave wrapper inside the Nios II CPU debug module.

Parameters:
- ADDR_W, 8, debug RAM word-address width (depth = 2^ADDR_W 32-bit words).
- INIT_FILE, "", optional RAM init file; empty means RAM content is undefined after power-up.

Ports:
- clk  in  1  system clock; all logic is on this one clock.
- reset_n  in  1  synchronous, active-low reset.
- jdo  in  38  JTAG data word from the debug-slave wrapper.
- take_action_ocimem_a  in  1  1-cycle strobe: load JTAG address / control.
- take_action_ocimem_b  in  1  1-cycle strobe: JTAG write.
- take_no_action_ocimem_a  in  1  1-cycle strobe: JTAG read.
- cpu_address  in  ADDR_W  CPU word address.
- cpu_read  in  1  CPU read request.
- cpu_write  in  1  CPU write request.
- cpu_writedata  in  32  CPU write data.
- cpu_byteenable  in  4  CPU byte lanes.
- cpu_readdata  out  32  CPU read data.
- cpu_waitrequest  out  1  Avalon waitrequest.
- MonDReg  out  32  last JTAG read data.
- monitor_ready  out  1  JTAG read data valid.
- monitor_error  out  1  sticky error flag.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State returns to IDLE; the pending JTAG slot clears; jmem_addr=0.
  - MonDReg=0, cpu_readdata=0, monitor_ready=0, monitor_error=0.
  - RAM contents are untouched. Any in-flight CPU read is dropped, and the CPU master must reissue it.
- JTAG strobe latch:
  - Any strobe is captured, together with `jdo`, into a single pending slot.
  - If several strobes assert in one cycle, priority is ocimem_a > ocimem_b > no_action_a.
  - A new strobe arriving while the slot is full overwrites it. Upstream TCK-rate spacing makes this benign.
- Pending command decode:
  - ocimem_a: jmem_addr <= jdo[ADDR_W+17:18]; monitor_ready <= 0; if jdo[34]=1, monitor_error <= 0. No RAM access.
  - ocimem_b: full-word write of jdo[34:3] at jmem_addr, then jmem_addr+1.
  - no_action_a: RAM read at jmem_addr, then jmem_addr+1.
  - The address increment wraps modulo 2^ADDR_W (top address goes to 0).
- FSM states: IDLE, JRD, CRD. The RAM has a 1-cycle synchronous read.
- IDLE:
  - A pending JTAG command is serviced first.
    - ocimem_a or ocimem_b completes in this cycle; the FSM stays in IDLE and the slot clears.
    - no_action_a issues the RAM read and moves to JRD.
  - Otherwise, if cpu_write: byte-enabled write, cpu_waitrequest=0 in that cycle (zero-wait write), stay in IDLE.
  - Otherwise, if cpu_read: issue the RAM read, cpu_waitrequest=1, move to CRD.
- JRD: MonDReg <= RAM data; monitor_ready <= 1; the slot clears; return to IDLE. Any CPU request is held with waitrequest=1.
- CRD: cpu_readdata <= RAM data is presented and cpu_waitrequest=0 in this cycle; return to IDLE. CPU read latency is 2 cycles (1 wait).
- cpu_waitrequest:
  - 1 whenever cpu_read or cpu_write is asserted and the access is not completing this cycle.
  - 0 when there is no request.
- JTAG has strict priority. A JTAG strobe arriving while in CRD is serviced on the next IDLE cycle.
- cpu_read and cpu_write asserted together is illegal; the write is taken.

Optional Feature:
- Macro: DEBUG_RAM_PARITY_EN.
- Defined:
  - RAM becomes 36 bits wide, with one even-parity bit per byte written alongside each byte lane.
  - A parity mismatch on any JRD or CRD read sets monitor_error=1 (sticky). The read data is still returned.
  - monitor_error is cleared only by ocimem_a with jdo[34]=1, or by reset.
- Undefined: RAM is 32 bits wide and monitor_error is constant 0.

Test Plan:
- Reset, then ocimem_a with jdo[25:18]=0x10, then ocimem_b with jdo[34:3]=0xDEADBEEF, then ocimem_a with addr 0x10, then no_action_a -> MonDReg=0xDEADBEEF and monitor_ready=1 two cycles after the strobe; jmem_addr=0x11.
- JTAG write at addr 0xFF, then a JTAG read at 0x00 via auto-increment -> wrap observed; address is 0x01 after the read.
- CPU write 0x12345678 with byteenable=4'b0011 over an existing 0xAAAAAAAA at addr 5, then CPU read addr 5 -> cpu_readdata=0xAAAA5678, waitrequest high exactly 1 cycle.
- CPU read in progress (CRD) when no_action_a strobes -> CPU read completes first; JTAG read completes within 2 further cycles; the JTAG strobe is not lost.
- reset_n=0 asserted during JRD -> MonDReg=0, monitor_ready=0, state IDLE; RAM word is unchanged on a later read.
- DEBUG_RAM_PARITY_EN: force a parity bit flip, then CPU read -> monitor_error=1 and stays 1; ocimem_a with jdo[34]=1 -> monitor_error=0.
